// File: rtl/lfsr_req_arbiter_if.sv
// lfsr_req_arbiter_if: requester, control and lfsr-side signals of the shared lfsr arbiter
interface lfsr_req_arbiter_if #(parameter int N = 4, parameter int NREQ = 4, parameter int IDW = 2);
  logic start;
  logic stop;
  logic [N-1:0] seed_in;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic rvalid;
  logic [N-1:0] rdata;
  logic [IDW-1:0] rid;
  logic busy;
  logic [7:0] period_cnt;
  logic lfsr_load_seed;
  logic [N-1:0] lfsr_seed_data;
  logic [N-1:0] lfsr_data;
  logic lfsr_done;
  modport slave (
    input start, stop, seed_in, req, lfsr_data, lfsr_done,
    output gnt, rvalid, rdata, rid, busy, period_cnt, lfsr_load_seed, lfsr_seed_data
  );
  modport master (
    output start, stop, seed_in, req, lfsr_data, lfsr_done,
    input gnt, rvalid, rdata, rid, busy, period_cnt, lfsr_load_seed, lfsr_seed_data
  );
endinterface

// File: rtl/lfsr_req_arbiter.sv
// lfsr_req_arbiter: seeds one shared lfsr and round-robins its words to NREQ requesters; LFSR_AUTO_RESEED_EN restarts each period from seed_q
module lfsr_req_arbiter #(
  parameter int N = 4,
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input logic clk,
  input logic reset,
  lfsr_req_arbiter_if.slave b
);
  typedef enum logic [1:0] {IDLE, LOAD, WARM, RUN} state_t;
  state_t state, state_n;
  logic [N-1:0] seed_q, rdata_q;
  logic [IDW-1:0] ptr, sel, rid_q;
  logic [IDW:0] k;
  logic [7:0] pc_q;
  logic any, grant, auto_reseed, rvalid_q;
`ifdef LFSR_AUTO_RESEED_EN
  assign auto_reseed = state == RUN && b.lfsr_done;
`else
  assign auto_reseed = 1'b0;
`endif
  // scan from the highest offset down so the lowest offset from ptr wins
  always_comb begin
    sel = '0;
    any = 1'b0;
    k = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = {1'b0, ptr} + (IDW + 1)'(i);
      k = k >= (IDW + 1)'(NREQ) ? k - (IDW + 1)'(NREQ) : k;
      if (b.req[k[IDW-1:0]]) begin
        sel = k[IDW-1:0];
        any = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = b.stop ? IDLE : b.start ? LOAD : state == LOAD ? WARM : state == WARM ? RUN :
              state == RUN ? (auto_reseed ? LOAD : RUN) : IDLE;
    grant = state == RUN && !b.stop && !b.start && !auto_reseed && any;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      pc_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      rid_q <= '0;
      seed_q <= '0;
    end else begin
      rvalid_q <= grant;
      if (grant) begin
        rdata_q <= b.lfsr_data;
        rid_q <= sel;
        ptr <= sel == IDW'(NREQ - 1) ? '0 : sel + 1'b1;
      end
      if (b.start && !b.stop) begin
        seed_q <= b.seed_in == '0 ? N'(1) : b.seed_in;
        pc_q <= '0;
      end else if (state == RUN && b.lfsr_done && pc_q != 8'hff) pc_q <= pc_q + 8'd1;
    end
  end
  assign b.gnt = grant ? NREQ'(1) << sel : '0;
  assign b.rvalid = rvalid_q;
  assign b.rdata = rdata_q;
  assign b.rid = rid_q;
  assign b.period_cnt = pc_q;
  assign b.busy = state != IDLE;
  assign b.lfsr_load_seed = state == LOAD;
  assign b.lfsr_seed_data = seed_q;
endmodule

// File: tb/tb_lfsr_req_arbiter.sv
// tb_lfsr_req_arbiter: directed vector table plus period-count and reseed sequences for lfsr_req_arbiter
module tb_lfsr_req_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  lfsr_req_arbiter_if #(.N(4), .NREQ(4), .IDW(2)) b ();
  lfsr_req_arbiter #(.N(4), .NREQ(4), .IDW(2)) dut (.clk(clk), .reset(reset), .b(b));
  typedef struct {
    logic start, stop;
    logic [3:0] seed, req, ldata, gnt;
    logic busy, load;
    logic [3:0] sdata;
    logic rv;
    logic [3:0] rdata;
    logic [1:0] rid;
  } vec_t;
  vec_t tbl [29];
  int nvec = 0;
  int nerr = 0;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic st, input logic sp, input logic [3:0] sd, input logic [3:0] rq,
                       input logic [3:0] ld, input logic dn);
    b.start = st;
    b.stop = sp;
    b.seed_in = sd;
    b.req = rq;
    b.lfsr_data = ld;
    b.lfsr_done = dn;
  endtask
  function automatic logic [63:0] outs();
    return 64'({b.gnt, b.busy, b.lfsr_load_seed, b.lfsr_seed_data, b.rvalid, b.rdata, b.rid, b.period_cnt});
  endfunction
  initial begin
    // start stop seed req ldata | gnt busy load sdata rvalid rdata rid
    tbl[0]  = '{1'b0, 1'b0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0};
    tbl[1]  = '{1'b1, 1'b0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0};
    tbl[2]  = '{1'b0, 1'b0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b1, 1'b1, 4'h1, 1'b0, 4'h0, 2'd0};
    tbl[3]  = '{1'b0, 1'b0, 4'h0, 4'hf, 4'h1, 4'h0, 1'b1, 1'b0, 4'h1, 1'b0, 4'h0, 2'd0};
    tbl[4]  = '{1'b0, 1'b0, 4'h0, 4'hf, 4'h1, 4'h1, 1'b1, 1'b0, 4'h1, 1'b0, 4'h0, 2'd0};
    tbl[5]  = '{1'b0, 1'b0, 4'h0, 4'hf, 4'h2, 4'h2, 1'b1, 1'b0, 4'h1, 1'b1, 4'h1, 2'd0};
    tbl[6]  = '{1'b0, 1'b0, 4'h0, 4'hf, 4'h4, 4'h4, 1'b1, 1'b0, 4'h1, 1'b1, 4'h2, 2'd1};
    tbl[7]  = '{1'b0, 1'b0, 4'h0, 4'hf, 4'h9, 4'h8, 1'b1, 1'b0, 4'h1, 1'b1, 4'h4, 2'd2};
    tbl[8]  = '{1'b0, 1'b0, 4'h0, 4'hf, 4'h3, 4'h1, 1'b1, 1'b0, 4'h1, 1'b1, 4'h9, 2'd3};
    tbl[9]  = '{1'b0, 1'b0, 4'h0, 4'hf, 4'h6, 4'h2, 1'b1, 1'b0, 4'h1, 1'b1, 4'h3, 2'd0};
    tbl[10] = '{1'b0, 1'b0, 4'h0, 4'hf, 4'hd, 4'h4, 1'b1, 1'b0, 4'h1, 1'b1, 4'h6, 2'd1};
    tbl[11] = '{1'b0, 1'b0, 4'h0, 4'hf, 4'ha, 4'h8, 1'b1, 1'b0, 4'h1, 1'b1, 4'hd, 2'd2};
    tbl[12] = '{1'b0, 1'b0, 4'h0, 4'h4, 4'h7, 4'h4, 1'b1, 1'b0, 4'h1, 1'b1, 4'ha, 2'd3};
    tbl[13] = '{1'b0, 1'b0, 4'h0, 4'h3, 4'he, 4'h1, 1'b1, 1'b0, 4'h1, 1'b1, 4'h7, 2'd2};
    tbl[14] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'hf, 4'h0, 1'b1, 1'b0, 4'h1, 1'b1, 4'he, 2'd0};
    tbl[15] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h1, 1'b0, 4'he, 2'd0};
    tbl[16] = '{1'b0, 1'b0, 4'h0, 4'h2, 4'h8, 4'h2, 1'b1, 1'b0, 4'h1, 1'b0, 4'he, 2'd0};
    tbl[17] = '{1'b1, 1'b1, 4'h5, 4'hf, 4'hc, 4'h0, 1'b1, 1'b0, 4'h1, 1'b1, 4'h8, 2'd1};
    tbl[18] = '{1'b0, 1'b0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1, 1'b0, 4'h8, 2'd1};
    tbl[19] = '{1'b1, 1'b0, 4'h6, 4'hf, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1, 1'b0, 4'h8, 2'd1};
    tbl[20] = '{1'b0, 1'b0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b1, 1'b1, 4'h6, 1'b0, 4'h8, 2'd1};
    tbl[21] = '{1'b0, 1'b0, 4'h0, 4'hf, 4'h6, 4'h0, 1'b1, 1'b0, 4'h6, 1'b0, 4'h8, 2'd1};
    tbl[22] = '{1'b0, 1'b0, 4'h0, 4'hf, 4'h6, 4'h4, 1'b1, 1'b0, 4'h6, 1'b0, 4'h8, 2'd1};
    tbl[23] = '{1'b1, 1'b0, 4'h0, 4'hf, 4'hc, 4'h0, 1'b1, 1'b0, 4'h6, 1'b1, 4'h6, 2'd2};
    tbl[24] = '{1'b0, 1'b0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b1, 1'b1, 4'h1, 1'b0, 4'h6, 2'd2};
    tbl[25] = '{1'b0, 1'b0, 4'h0, 4'hf, 4'h1, 4'h0, 1'b1, 1'b0, 4'h1, 1'b0, 4'h6, 2'd2};
    tbl[26] = '{1'b0, 1'b0, 4'h0, 4'h9, 4'h1, 4'h8, 1'b1, 1'b0, 4'h1, 1'b0, 4'h6, 2'd2};
    tbl[27] = '{1'b0, 1'b1, 4'h0, 4'hf, 4'h5, 4'h0, 1'b1, 1'b0, 4'h1, 1'b1, 4'h1, 2'd3};
    tbl[28] = '{1'b0, 1'b0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1, 1'b0, 4'h1, 2'd3};
    drive(1'b0, 1'b0, 4'h0, 4'hf, 4'h0, 1'b0);
    tick;
    tick;
    #2;
    chk("reset", outs(), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].start, tbl[i].stop, tbl[i].seed, tbl[i].req, tbl[i].ldata, 1'b0);
      #2;
      chk($sformatf("vec%0d", i), outs(),
          64'({tbl[i].gnt, tbl[i].busy, tbl[i].load, tbl[i].sdata, tbl[i].rv, tbl[i].rdata, tbl[i].rid, 8'd0}));
      tick;
    end
    drive(1'b1, 1'b0, 4'h3, 4'h0, 4'h0, 1'b0);
    tick;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h3, 1'b0);
    tick;
    tick;
    for (int k = 0; k < 300; k++) begin
      if (k == 254) chk("pc_254", 64'(b.period_cnt), 64'd254);
      b.lfsr_done = 1'b1;
`ifdef LFSR_AUTO_RESEED_EN
      #2;
      chk("done_gnt", 64'({b.gnt, b.busy}), 64'h1);
      tick;
      b.lfsr_done = 1'b0;
      #2;
      chk("reseed_pulse", 64'({b.lfsr_load_seed, b.lfsr_seed_data}), 64'h13);
      tick;
      tick;
`else
      #2;
      chk("free_run", 64'({b.busy, b.lfsr_load_seed}), 64'h2);
      tick;
`endif
    end
    b.lfsr_done = 1'b0;
    #2;
    chk("pc_sat", 64'(b.period_cnt), 64'd255);
    b.start = 1'b1;
    b.seed_in = 4'h9;
    tick;
    b.start = 1'b0;
    #2;
    chk("restart_load", 64'({b.lfsr_load_seed, b.lfsr_seed_data}), 64'h19);
    tick;
    #2;
    chk("pc_clear", 64'({b.period_cnt, b.lfsr_load_seed, b.busy}), 64'h1);
    reset = 1'b1;
    b.req = 4'hf;
    tick;
    #2;
    chk("reset_run", outs(), 64'd0);
    reset = 1'b0;
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
